ht_sequencer: RTL and testbench

HT_SEQUENCER -- requirements
Module: ht_sequencer

---
 rtl/ht_sequencer.sv | 145 ++++++++++++++
 tb/tb_ht_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ht_sequencer.sv
// Hidden-state sequencer: buffers samples, streams t of them plus one tail cycle to an
// averager, then captures its result. Define HT_SEQ_DONE_SYNC_EN to synchronise done_in.
module ht_sequencer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clkl,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [7:0]  t,
  input  logic        go,
  input  logic        done_in,
  input  logic [15:0] ave_in,
  output logic [15:0] ht,
  output logic        start,
  output logic [15:0] ave_out,
  output logic        ave_valid,
  output logic        busy,
  output logic        full,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, STREAM, TAIL, WAIT} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    remain;
  logic          push, pop, capture;
  logic          t_fits, go_ok, go_bad;
  logic          done_src, done_r, done_d, done_rise;

  assign full   = (count == (AW+1)'(DEPTH));
  assign push   = wr_en && !full;
  assign busy   = (state != IDLE);
  assign t_fits = (t != 8'd0) && ({1'b0, t} <= 9'(count));
  assign go_ok  = go && (state == IDLE) && t_fits;
  assign go_bad = go && (state == IDLE) && !t_fits;

  // NOTE: the sample store has no reset; occupancy and pointers define which entries are
  // meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clkl) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers see the
  // pre-edge values of each other, independent of block evaluation order.
  always_ff @(posedge clkl or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef HT_SEQ_DONE_SYNC_EN
  logic [1:0] done_sync;

  always_ff @(posedge clkl or negedge rst_n) begin
    if (!rst_n) done_sync <= '0;
    else        done_sync <= {done_sync[0], done_in};
  end

  assign done_src = done_sync[1];
`else
  assign done_src = done_in;
`endif

  // Edge detector runs in every state so a done level left over from an earlier run
  // never looks like a fresh completion.
  always_ff @(posedge clkl or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      done_d <= 1'b0;
    end else begin
      done_r <= done_src;
      done_d <= done_r;
    end
  end

  assign done_rise = done_r && !done_d;

  always_ff @(posedge clkl or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ht        = '0;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (go_ok) state_nxt = STREAM;
      end
      STREAM: begin
        start = 1'b1;
        ht    = mem[rd_ptr];
        pop   = 1'b1;
        if (remain == 8'd1) state_nxt = TAIL;
      end
      TAIL: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkl or negedge rst_n) begin
    if (!rst_n) begin
      remain    <= '0;
      ave_out   <= '0;
      ave_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (go_ok)    remain <= t;
      else if (pop) remain <= remain - 8'd1;
      if (capture)  ave_out <= ave_in;
      ave_valid <= capture;
      err       <= go_bad;
    end
  end

endmodule

// File: tb/tb_ht_sequencer.sv
// Randomised scoreboard bench for ht_sequencer: the driver queues expected ht, average
// and err events from a sample-queue model; a negedge monitor consumes them.
module tb_ht_sequencer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clkl = 1'b0;
  logic        rst_n, wr_en, go, done_in;
  logic [15:0] wr_data, ave_in;
  logic [7:0]  t;
  logic [15:0] ht, ave_out;
  logic        start, ave_valid, busy, full, err;

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [15:0] mq[$];
  logic [15:0] exp_ht[$];
  logic [15:0] exp_ave[$];
  int          exp_err = 0;
  bit          run_active = 1'b0;
  logic [15:0] mon_e;

  ht_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clkl(clkl), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .t(t), .go(go),
    .done_in(done_in), .ave_in(ave_in), .ht(ht), .start(start), .ave_out(ave_out),
    .ave_valid(ave_valid), .busy(busy), .full(full), .err(err)
  );

  always #5 clkl = ~clkl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clkl) begin
    if (rst_n) begin
      if (start) begin
        check("start_expected", 32'(exp_ht.size() != 0), 1);
        if (exp_ht.size() != 0) begin
          mon_e = exp_ht.pop_front();
          check("ht_stream", 32'(ht), 32'(mon_e));
        end
        check("busy_in_run", 32'(busy), 1);
      end else begin
        check("ht_idle_zero", 32'(ht), 0);
      end
      if (ave_valid) begin
        check("ave_valid_expected", 32'(exp_ave.size() != 0), 1);
        if (exp_ave.size() != 0) begin
          mon_e = exp_ave.pop_front();
          check("ave_out", 32'(ave_out), 32'(mon_e));
        end
      end
      if (err) begin
        check("err_expected", 32'(exp_err != 0), 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic cyc();
    @(posedge clkl);
    #1;
  endtask

  // One cycle of stimulus; the model decides go against the occupancy before this edge.
  task automatic step(input bit we, input logic [15:0] wd, input bit g, input logic [7:0] tv);
    bit acc_push;
    acc_push = we && (mq.size() < DEPTH);
    wr_en = we; wr_data = wd; go = g; t = tv;
    if (g && !run_active) begin
      if (tv == 0 || int'(tv) > mq.size()) exp_err++;
      else begin
        for (int i = 0; i < int'(tv); i++) exp_ht.push_back(mq.pop_front());
        exp_ht.push_back(16'h0000);
        run_active = 1'b1;
      end
    end
    if (acc_push) mq.push_back(wd);
    cyc();
    wr_en = 1'b0; go = 1'b0;
  endtask

  task automatic wait_err();
    for (int i = 0; i < 6 && exp_err != 0; i++) cyc();
    check("err_seen", 32'(exp_err), 0);
    exp_err = 0;
  endtask

  task automatic drain_stream(input bit noisy);
    bit we;
    int n = 0;
    while (exp_ht.size() != 0 && n < 300) begin
      if (noisy) begin
        we = ($urandom_range(0, 3) == 0) && (mq.size() + exp_ht.size() < DEPTH);
        step(we, 16'($urandom), $urandom_range(0, 7) == 0, 8'($urandom));
      end else begin
        cyc();
      end
      n++;
    end
    check("stream_drained", 32'(exp_ht.size()), 0);
    exp_ht.delete();
  endtask

  // mode 0: one-cycle done pulse, 1: level then released, 2: level left high afterwards.
  task automatic finish_run(input logic [15:0] ave, input int mode, input bit noisy);
    int n = 0;
    drain_stream(noisy);
    check("wait_busy", 32'(busy), 1);
    check("wait_start", 32'(start), 0);
    if (done_in) begin
      repeat (3) cyc();
      check("held_done_no_capture", 32'(busy), 1);
      done_in = 1'b0;
      repeat (2) cyc();
    end
    ave_in = ave;
    exp_ave.push_back(ave);
    done_in = 1'b1;
    if (mode == 0) begin
      cyc();
      done_in = 1'b0;
    end
    while (exp_ave.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    check("ave_captured", 32'(exp_ave.size()), 0);
    exp_ave.delete();
    check("idle_after_capture", 32'(busy), 0);
    check("ave_out_hold", 32'(ave_out), 32'(ave));
    if (mode == 1) done_in = 1'b0;
    run_active = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_start", 32'(start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ht", 32'(ht), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ave_valid", 32'(ave_valid), 0);
    check("rst_ave_out", 32'(ave_out), 0);
    mq.delete(); exp_ht.delete(); exp_ave.delete();
    exp_err = 0; run_active = 1'b0;
    wr_en = 1'b0; go = 1'b0; done_in = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv;
    rst_n = 1'b1; wr_en = 1'b0; wr_data = '0; t = '0; go = 1'b0;
    done_in = 1'b0; ave_in = '0;
    #2;
    do_reset();

    // Four samples streamed as 1,2,3,4 then tail zero; capture 0x0002.
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 8'd0);
    step(1'b0, 16'h0, 1'b1, 8'd4);
    finish_run(16'h0002, 1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 8'd1);
    wait_err();

    // Rejected go: t beyond occupancy, then t of zero; occupancy must still be 3.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 8'd0);
    step(1'b0, 16'h0, 1'b1, 8'd5);
    wait_err();
    check("no_start_after_err", 32'(start), 0);
    step(1'b0, 16'h0, 1'b1, 8'd0);
    wait_err();
    step(1'b0, 16'h0, 1'b1, 8'd3);
    finish_run(16'hFFFE, 0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 8'd1);
    wait_err();

    // Fill to DEPTH, overflow write dropped, full run streams originals; done left high.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 8'd0);
    check("full_at_depth", 32'(full), 1);
    step(1'b1, 16'h7FFF, 1'b0, 8'd0);
    check("full_after_drop", 32'(full), 1);
    step(1'b0, 16'h0, 1'b1, 8'(DEPTH));
    finish_run(16'h1234, 2, 1'b0);
    check("not_full_after_run", 32'(full), 0);

    // done still high from the previous run must not capture early.
    step(1'b1, 16'h0011, 1'b0, 8'd0);
    step(1'b1, 16'h0022, 1'b0, 8'd0);
    step(1'b0, 16'h0, 1'b1, 8'd2);
    finish_run(16'h8001, 1, 1'b0);

    // Reset in the middle of a stream.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 8'd0);
    step(1'b0, 16'h0, 1'b1, 8'd4);
    cyc();
    do_reset();
    step(1'b0, 16'h0, 1'b1, 8'd1);
    wait_err();

    // Randomised runs with concurrent writes and ignored go pulses.
    repeat (40) begin
      repeat ($urandom_range(0, 5)) step(1'b1, 16'($urandom), 1'b0, 8'd0);
      if ($urandom_range(0, 3) != 0) begin
        tv = $urandom_range(0, mq.size() + 2);
        step($urandom_range(0, 1) == 1, 16'($urandom), 1'b1, 8'(tv));
        if (run_active) finish_run(16'($urandom), $urandom_range(0, 2), 1'b1);
        else wait_err();
      end
    end

    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
